// File: rtl/pong_pkg.sv
// Shared types and widths for the pong datapath: match state encoding,
// score/level widths and default match rules used by score, audio and paddle blocks.
package pong_pkg;

    localparam int SCORE_W       = 3;
    localparam int LEVEL_W       = 3;
    localparam int WIN_SCORE_DEF = 7;
    localparam int MAX_LEVEL_DEF = 7;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SERVE       = 3'd1,
        RALLY       = 3'd2,
        POINT_PAUSE = 3'd3,
        PAUSED      = 3'd4,
        LEVEL_UP    = 3'd5,
        GAME_OVER   = 3'd6
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/match_sequencer_if.sv
// Bundle of match-control inputs and sequencer outputs shared by the pong blocks.
// All inputs are sampled on the rising clock edge with no back-pressure: start is a level, the rest are one-cycle pulses.
interface match_sequencer_if;

    logic                         start;
    logic                         pause_req;
    logic                         p1_point;
    logic                         p2_point;
    logic                         ball_rst;
    logic                         game_on;
    logic                         serve_dir;
    logic [pong_pkg::SCORE_W-1:0] p1_total;
    logic [pong_pkg::SCORE_W-1:0] p2_total;
    logic [pong_pkg::LEVEL_W-1:0] level;
    logic                         point_evt;
    logic                         lvl_up;
    logic                         win;
    logic                         winner;
    logic [2:0]                   state_o;

    modport master (
        output start, pause_req, p1_point, p2_point,
        input  ball_rst, game_on, serve_dir, p1_total, p2_total, level,
        input  point_evt, lvl_up, win, winner, state_o
    );

    modport slave (
        input  start, pause_req, p1_point, p2_point,
        output ball_rst, game_on, serve_dir, p1_total, p2_total, level,
        output point_evt, lvl_up, win, winner, state_o
    );

endinterface

// File: rtl/match_sequencer_phase_timer.sv
// Loadable down-counter for timed match phases; done flags a count of zero.
// Loading D-1 on entry and leaving when done gives a phase of exactly D cycles.
module phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/match_sequencer.sv
// Match-flow controller: sequences serve, rally, point pause, pause, level-up and
// game-over, and owns the authoritative score, level and winner registers.
module match_sequencer
    import pong_pkg::*;
#(
    parameter int SERVE_CYCLES   = 25_000_000,
    parameter int POINT_CYCLES   = 50_000_000,
    parameter int LEVELUP_CYCLES = 100_000_000,
    parameter int WIN_SCORE      = WIN_SCORE_DEF,
    parameter int MAX_LEVEL      = MAX_LEVEL_DEF
) (
    input  logic                clk,
    input  logic                reset,
    match_sequencer_if.slave    bus
);

    localparam int MAX_CYC = max3(SERVE_CYCLES, POINT_CYCLES, LEVELUP_CYCLES);
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0]   SERVE_LD = TMR_W'(SERVE_CYCLES - 1);
    localparam logic [TMR_W-1:0]   POINT_LD = TMR_W'(POINT_CYCLES - 1);
    localparam logic [TMR_W-1:0]   LVLUP_LD = TMR_W'(LEVELUP_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN_S    = SCORE_W'(WIN_SCORE);
    localparam logic [LEVEL_W-1:0] MAX_L    = LEVEL_W'(MAX_LEVEL);

    state_t               state_q, state_d;
    logic [SCORE_W-1:0]   p1_q, p1_d, p2_q, p2_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic                 dir_q, dir_d, winner_q, winner_d;
    logic                 evt_q, evt_d, lup_q, lup_d, win_q, win_d;
    logic                 tmr_load, tmr_done;
    logic [TMR_W-1:0]     tmr_val;

    phase_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            p1_q     <= '0;
            p2_q     <= '0;
            level_q  <= '0;
            dir_q    <= 1'b0;
            winner_q <= 1'b0;
            evt_q    <= 1'b0;
            lup_q    <= 1'b0;
            win_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            level_q  <= level_d;
            dir_q    <= dir_d;
            winner_q <= winner_d;
            evt_q    <= evt_d;
            lup_q    <= lup_d;
            win_q    <= win_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        level_d  = level_q;
        dir_d    = dir_q;
        winner_d = winner_q;
        evt_d    = 1'b0;
        lup_d    = 1'b0;
        win_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            IDLE, GAME_OVER: begin
                if (bus.start) begin
                    state_d  = SERVE;
                    p1_d     = '0;
                    p2_d     = '0;
                    level_d  = '0;
                    winner_d = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = SERVE_LD;
                end
            end
            SERVE: if (tmr_done) state_d = RALLY;
            RALLY: begin
                if (bus.p1_point && bus.p2_point) begin
                    // Simultaneous points cancel out; the rally simply restarts.
                    state_d  = POINT_PAUSE;
                    tmr_load = 1'b1;
                    tmr_val  = POINT_LD;
                end else if (bus.p1_point || bus.p2_point) begin
                    evt_d = 1'b1;
                    dir_d = bus.p1_point;
                    if (bus.p1_point) p1_d = p1_q + SCORE_W'(1);
                    else              p2_d = p2_q + SCORE_W'(1);
                    if (p1_d == WIN_S || p2_d == WIN_S) begin
                        // Level win is resolved on the scoring edge itself.
                        win_d    = 1'b1;
                        winner_d = bus.p2_point;
                        if (level_q == MAX_L) begin
                            state_d = GAME_OVER;
                        end else begin
                            state_d  = LEVEL_UP;
                            level_d  = level_q + LEVEL_W'(1);
                            lup_d    = 1'b1;
                            p1_d     = '0;
                            p2_d     = '0;
                            tmr_load = 1'b1;
                            tmr_val  = LVLUP_LD;
                        end
                    end else begin
                        state_d  = POINT_PAUSE;
                        tmr_load = 1'b1;
                        tmr_val  = POINT_LD;
                    end
                end else if (bus.pause_req) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: if (bus.pause_req) state_d = RALLY;
            POINT_PAUSE, LEVEL_UP: begin
                if (tmr_done) begin
                    state_d  = SERVE;
                    tmr_load = 1'b1;
                    tmr_val  = SERVE_LD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ball control is a pure decode of the registered state.
    always_comb begin
        bus.ball_rst  = !(state_q == RALLY || state_q == PAUSED);
        bus.game_on   = (state_q == SERVE || state_q == RALLY);
        bus.state_o   = state_q;
        bus.serve_dir = dir_q;
        bus.p1_total  = p1_q;
        bus.p2_total  = p2_q;
        bus.level     = level_q;
        bus.point_evt = evt_q;
        bus.lvl_up    = lup_q;
        bus.win       = win_q;
        bus.winner    = winner_q;
    end

endmodule

// File: tb/tb_match_sequencer.sv
// Directed scoreboard bench for match_sequencer with short timers
// (serve 4, point 3, level-up 5, win at 3, last level 1).
module tb_match_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_RALLY = 3'd2,
                           S_PP = 3'd3, S_PAUSED = 3'd4, S_LUP = 3'd5, S_GO = 3'd6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    match_sequencer_if bus();

    match_sequencer #(
        .SERVE_CYCLES   (4),
        .POINT_CYCLES   (3),
        .LEVELUP_CYCLES (5),
        .WIN_SCORE      (3),
        .MAX_LEVEL      (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Expected post-edge values, maintained by hand in the stimulus sequence.
    logic [2:0] e_state = S_IDLE;
    logic [2:0] e_p1 = '0, e_p2 = '0, e_lvl = '0;
    logic       e_dir = 1'b0, e_wnr = 1'b0, e_evt = 1'b0, e_lup = 1'b0, e_win = 1'b0;

    logic [18:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          fails = 0;

    function automatic logic [18:0] pack_exp();
        logic brst, gon;
        brst = !(e_state == S_RALLY || e_state == S_PAUSED);
        gon  = (e_state == S_SERVE || e_state == S_RALLY);
        return {e_state, brst, gon, e_dir, e_p1, e_p2, e_lvl, e_evt, e_lup, e_win, e_wnr};
    endfunction

    task automatic tick(input string name, input logic st, input logic pr,
                        input logic a, input logic b);
        bus.start     = st;
        bus.pause_req = pr;
        bus.p1_point  = a;
        bus.p2_point  = b;
        @(posedge clk);
        exp_q.push_back(pack_exp());
        name_q.push_back(name);
        #1;
        bus.start = 1'b0; bus.pause_req = 1'b0; bus.p1_point = 1'b0; bus.p2_point = 1'b0;
        e_evt = 1'b0; e_lup = 1'b0; e_win = 1'b0;
    endtask

    task automatic hold(input string name, input int n);
        for (int i = 0; i < n; i++) tick(name, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic serve_to_rally();
        e_state = S_SERVE; tick("enter_serve", 1'b0, 1'b0, 1'b0, 1'b0);
        hold("serve", 3);
        e_state = S_RALLY; tick("serve_expire", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pp_then_serve();
        hold("point_pause", 2);
        serve_to_rally();
    endtask

    always @(negedge clk) begin
        logic [18:0] act, exp_v;
        string       nm;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act   = {bus.state_o, bus.ball_rst, bus.game_on, bus.serve_dir, bus.p1_total,
                     bus.p2_total, bus.level, bus.point_evt, bus.lvl_up, bus.win, bus.winner};
            checks++;
            if (act !== exp_v) begin
                fails++;
                $display("FAIL %s: got %b required %b (state,brst,gon,dir,p1,p2,lvl,evt,lup,win,wnr) t=%0t",
                         nm, act, exp_v, $time);
            end
        end
    end

    initial begin
        bus.start = 1'b0; bus.pause_req = 1'b0; bus.p1_point = 1'b0; bus.p2_point = 1'b0;

        reset = 1'b1;
        tick("reset", 1'b1, 1'b1, 1'b1, 1'b0);
        tick("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick("idle_no_start", 1'b0, 1'b1, 1'b1, 1'b1);

        e_state = S_SERVE;
        tick("start", 1'b1, 1'b0, 1'b0, 1'b0);
        tick("serve_start_ignored", 1'b1, 1'b0, 1'b1, 1'b0);
        tick("serve_pause_ignored", 1'b0, 1'b1, 1'b0, 1'b1);
        hold("serve", 1);
        e_state = S_RALLY;
        tick("serve_expire", 1'b0, 1'b0, 1'b0, 1'b0);
        hold("rally", 2);

        e_state = S_PP; e_p1 = 3'd1; e_dir = 1'b1; e_evt = 1'b1;
        tick("p1_point", 1'b0, 1'b0, 1'b1, 1'b0);
        pp_then_serve();

        e_state = S_PP; e_p2 = 3'd1; e_dir = 1'b0; e_evt = 1'b1;
        tick("p2_point_1", 1'b0, 1'b0, 1'b0, 1'b1);
        pp_then_serve();
        e_state = S_PP; e_p2 = 3'd2; e_evt = 1'b1;
        tick("p2_point_2", 1'b0, 1'b0, 1'b0, 1'b1);
        pp_then_serve();
        e_state = S_LUP; e_p1 = '0; e_p2 = '0; e_lvl = 3'd1; e_wnr = 1'b1;
        e_evt = 1'b1; e_lup = 1'b1; e_win = 1'b1;
        tick("p2_level_win", 1'b0, 1'b0, 1'b0, 1'b1);
        tick("level_up_start_ignored", 1'b1, 1'b0, 1'b0, 1'b0);
        hold("level_up", 3);
        serve_to_rally();

        e_state = S_PP; e_p1 = 3'd1; e_dir = 1'b1; e_evt = 1'b1;
        tick("l1_p1_point_1", 1'b0, 1'b0, 1'b1, 1'b0);
        pp_then_serve();
        e_state = S_PP; e_p1 = 3'd2; e_evt = 1'b1;
        tick("l1_p1_point_2", 1'b0, 1'b0, 1'b1, 1'b0);
        pp_then_serve();
        e_state = S_GO; e_p1 = 3'd3; e_wnr = 1'b0; e_evt = 1'b1; e_win = 1'b1;
        tick("match_win", 1'b0, 1'b0, 1'b1, 1'b0);
        tick("game_over_hold", 1'b0, 1'b1, 1'b1, 1'b0);
        hold("game_over_hold", 1);
        e_state = S_SERVE; e_p1 = '0; e_lvl = '0;
        tick("restart", 1'b1, 1'b0, 1'b0, 1'b0);
        hold("serve", 3);
        e_state = S_RALLY;
        tick("serve_expire", 1'b0, 1'b0, 1'b0, 1'b0);

        e_state = S_PAUSED;
        tick("pause", 1'b0, 1'b1, 1'b0, 1'b0);
        tick("paused_point_ignored", 1'b0, 1'b0, 1'b1, 1'b0);
        tick("paused_start_ignored", 1'b1, 1'b0, 1'b0, 1'b1);
        e_state = S_RALLY;
        tick("resume", 1'b0, 1'b1, 1'b0, 1'b0);

        e_state = S_PP;
        tick("both_points", 1'b0, 1'b0, 1'b1, 1'b1);
        pp_then_serve();

        e_state = S_PP; e_p2 = 3'd1; e_dir = 1'b0; e_evt = 1'b1;
        tick("point_beats_pause", 1'b0, 1'b1, 1'b0, 1'b1);
        hold("point_pause", 1);
        reset = 1'b1;
        e_state = S_IDLE; e_p1 = '0; e_p2 = '0; e_lvl = '0; e_dir = 1'b0; e_wnr = 1'b0;
        tick("reset_mid_pause", 1'b1, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        tick("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/match_sequencer.md
Name: match_sequencer

Overview:
- Central match-flow controller for the pong datapath. Sequences serve delay, rally, point pause, pause/resume, level-up and game-over.
- Drives the ball block's reset and run enables and owns the authoritative score and level registers.
- Consumes the per-point pulses from the ball block. Its score and level outputs feed the score/LCD block, the audio block and the paddle controllers.

Parameters:
- SERVE_CYCLES, 25_000_000: cycles the ball is held at centre before each serve (>=1).
- POINT_CYCLES, 50_000_000: cycles of post-point pause (>=1).
- LEVELUP_CYCLES, 100_000_000: cycles of level-up banner/sound pause (>=1).
- WIN_SCORE, 7: points needed to win a level (1..7).
- MAX_LEVEL, 7: last level; a win at this level ends the match (0..7).

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- start  in  1  start/restart request, level-sampled each cycle
- pause_req  in  1  one-cycle pulse that toggles pause
- p1_point  in  1  one-cycle pulse: player 1 scored
- p2_point  in  1  one-cycle pulse: player 2 scored
- ball_rst  out  1  high holds ball at centre
- game_on  out  1  high enables ball motion and paddle motion
- serve_dir  out  1  0 = serve toward player 1, 1 = toward player 2
- p1_total  out  3  player 1 score in current level
- p2_total  out  3  player 2 score in current level
- level  out  3  current level
- point_evt  out  1  one-cycle pulse on every scored point
- lvl_up  out  1  one-cycle pulse on level advance
- win  out  1  one-cycle pulse when a level is won
- winner  out  1  0 = P1, 1 = P2; valid from the win pulse onward
- state_o  out  3  current state encoding (debug/display)

Behaviour:
- All outputs are registered. An event sampled at edge N is visible after edge N.
- Reset state: IDLE, ball_rst=1, game_on=0, serve_dir=0, scores=0, level=0, winner=0, all pulses 0, timer=0. Reset overrides all inputs.
- States are IDLE, SERVE, RALLY, POINT_PAUSE, PAUSED, LEVEL_UP, GAME_OVER.
- Combinational state decode:
  - ball_rst=0 only in RALLY and PAUSED.
  - game_on=1 only in SERVE and RALLY.
- Timer: a down-counter loaded with D-1 on entry to a timed state. The state exits when the timer is 0, so the state lasts exactly D cycles.
- IDLE: start=1 -> SERVE. Scores and level are cleared to 0 and the timer is loaded with SERVE_CYCLES.
- SERVE: timer expiry -> RALLY. Point inputs and pause_req are ignored.
- RALLY, single point:
  - p1_point alone: p1_total+1, point_evt=1, serve_dir=1.
  - p2_point alone: p2_total+1, point_evt=1, serve_dir=0.
  - If the incremented total == WIN_SCORE -> LEVEL_UP; otherwise -> POINT_PAUSE with the timer loaded with POINT_CYCLES.
- RALLY, both point pulses in the same cycle: no score change, no point_evt, serve_dir unchanged, -> POINT_PAUSE.
- RALLY, pause_req alone -> PAUSED. If a point pulse coincides with pause_req, the point wins and pause_req is dropped.
- PAUSED: pause_req -> RALLY. Point inputs are ignored. The ball holds position because game_on=0 and ball_rst=0.
- POINT_PAUSE: timer expiry -> SERVE with the timer loaded with SERVE_CYCLES.
- LEVEL_UP, entry cycle: win=1 and winner is latched.
  - If level == MAX_LEVEL -> GAME_OVER. No lvl_up pulse; scores are held for display.
  - Otherwise: level+1, lvl_up=1, scores cleared, timer loaded with LEVELUP_CYCLES. The state holds until expiry, then -> SERVE with the timer loaded with SERVE_CYCLES.
  - The win and lvl_up pulses fire together, on the entry edge only.
- GAME_OVER: start=1 -> SERVE with scores, level and winner cleared.
- start is ignored in all states except IDLE and GAME_OVER.
- Scores never exceed WIN_SCORE, so there is no wrap. Level never exceeds MAX_LEVEL.
- Reset mid-timer or mid-PAUSED: return immediately to IDLE with reset values, and no pulse is emitted.

Decomposition:
- Package pong_pkg:
  - state_t enum with encodings IDLE=0, SERVE=1, RALLY=2, POINT_PAUSE=3, PAUSED=4, LEVEL_UP=5, GAME_OVER=6.
  - SCORE_W=3, LEVEL_W=3, and the default WIN_SCORE/MAX_LEVEL constants, shared with the score and audio blocks.
- One sub-module, phase_timer:
  - Parameterised width.
  - Ports: load, load_val, done.
  - Reset to 0 synchronously, with done = (count==0).

Test Plan (SERVE_CYCLES=4, POINT_CYCLES=3, LEVELUP_CYCLES=5, WIN_SCORE=3, MAX_LEVEL=1):
- Reset, then start pulse -> state_o=SERVE with game_on=1 and ball_rst=1 for exactly 4 cycles, then RALLY with ball_rst=0.
- In RALLY, p1_point -> p1_total=1, point_evt high 1 cycle, serve_dir=1, POINT_PAUSE 3 cycles, SERVE 4 cycles, RALLY.
- p2 scores 3 times at level 0 -> on the 3rd point: win=1, lvl_up=1, winner=1, level=1, scores=0, LEVEL_UP for 5 cycles, then SERVE.
- At level 1, p1 reaches 3 -> win=1, lvl_up=0, state_o=GAME_OVER, p1_total=3 held; start -> SERVE with level=0 and scores=0.
- In RALLY, pause_req -> PAUSED (game_on=0, ball_rst=0); p1_point while PAUSED is ignored; pause_req -> RALLY.
- p1_point and p2_point together -> no score change, POINT_PAUSE. pause_req with p2_point -> p2_total+1 and no pause. Reset asserted mid-POINT_PAUSE -> IDLE next cycle with all outputs at reset values.
